// File: rtl/alu_pkg.sv
// Shared ALU function codes, MIPS opcode/funct constants and the decoded-op record
// passed from decode to the issue buffer.
package alu_pkg;

  localparam int unsigned DataW = 32;

  localparam logic [5:0] FnAdd   = 6'b000000;
  localparam logic [5:0] FnSub   = 6'b000001;
  localparam logic [5:0] FnAnd   = 6'b011000;
  localparam logic [5:0] FnOr    = 6'b011110;
  localparam logic [5:0] FnXor   = 6'b010110;
  localparam logic [5:0] FnNor   = 6'b010001;
  localparam logic [5:0] FnPassA = 6'b011010;
  localparam logic [5:0] FnSll   = 6'b100000;
  localparam logic [5:0] FnSrl   = 6'b100001;
  localparam logic [5:0] FnSra   = 6'b100011;
  localparam logic [5:0] FnEq    = 6'b110011;
  localparam logic [5:0] FnNeq   = 6'b110001;
  localparam logic [5:0] FnLt    = 6'b110101;
  localparam logic [5:0] FnLez   = 6'b111101;
  localparam logic [5:0] FnGez   = 6'b111001;
  localparam logic [5:0] FnGtz   = 6'b111111;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpBlez  = 6'h06;
  localparam logic [5:0] OpBgtz  = 6'h07;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAddiu = 6'h09;
  localparam logic [5:0] OpSlti  = 6'h0a;
  localparam logic [5:0] OpSltiu = 6'h0b;
  localparam logic [5:0] OpAndi  = 6'h0c;
  localparam logic [5:0] OpOri   = 6'h0d;
  localparam logic [5:0] OpXori  = 6'h0e;
  localparam logic [5:0] OpLui   = 6'h0f;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;

  localparam logic [5:0] FtSll   = 6'h00;
  localparam logic [5:0] FtSrl   = 6'h02;
  localparam logic [5:0] FtSra   = 6'h03;
  localparam logic [5:0] FtSllv  = 6'h04;
  localparam logic [5:0] FtSrlv  = 6'h06;
  localparam logic [5:0] FtSrav  = 6'h07;
  localparam logic [5:0] FtAdd   = 6'h20;
  localparam logic [5:0] FtAddu  = 6'h21;
  localparam logic [5:0] FtSub   = 6'h22;
  localparam logic [5:0] FtSubu  = 6'h23;
  localparam logic [5:0] FtAnd   = 6'h24;
  localparam logic [5:0] FtOr    = 6'h25;
  localparam logic [5:0] FtXor   = 6'h26;
  localparam logic [5:0] FtNor   = 6'h27;
  localparam logic [5:0] FtSlt   = 6'h2a;
  localparam logic [5:0] FtSltu  = 6'h2b;

  // 'signed' is a keyword, hence is_signed for the ALU Signed input.
  typedef struct packed {
    logic [DataW-1:0] a;
    logic [DataW-1:0] b;
    logic             is_signed;
    logic [5:0]       func;
    logic [4:0]       dst;
    logic             wen;
    logic             illegal;
  } alu_op_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational MIPS decode: instruction plus register values to ALU operands,
// function code and writeback control.
import alu_pkg::*;

module alu_decode (
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output alu_op_t     op
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic        legal;
  alu_op_t     dec;

  // rs is consumed as a value, its index field is never needed here.
  logic unused_rs;
  assign unused_rs = ^instr[25:21];

  assign opcode   = instr[31:26];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign shamt    = instr[10:6];
  assign funct    = instr[5:0];
  assign imm_sext = {{16{instr[15]}}, instr[15:0]};
  assign imm_zext = {16'd0, instr[15:0]};

  always_comb begin
    dec       = '0;
    legal     = 1'b1;
    // I-type defaults; R-type and branches override.
    dec.func  = FnAdd;
    dec.a     = rs_val;
    dec.dst   = rt;
    dec.wen   = 1'b1;
    case (opcode)
      OpRtype: begin
        dec.b   = rt_val;
        dec.dst = rd;
        case (funct)
          FtAdd:   begin dec.func = FnAdd; dec.is_signed = 1'b1; end
          FtAddu:  dec.func = FnAdd;
          FtSub:   begin dec.func = FnSub; dec.is_signed = 1'b1; end
          FtSubu:  dec.func = FnSub;
          FtAnd:   dec.func = FnAnd;
          FtOr:    dec.func = FnOr;
          FtXor:   dec.func = FnXor;
          FtNor:   dec.func = FnNor;
          FtSlt:   begin dec.func = FnLt; dec.is_signed = 1'b1; end
          FtSltu:  dec.func = FnLt;
          FtSll:   begin dec.func = FnSll; dec.a = {27'd0, shamt}; end
          FtSrl:   begin dec.func = FnSrl; dec.a = {27'd0, shamt}; end
          FtSra:   begin dec.func = FnSra; dec.a = {27'd0, shamt}; end
          FtSllv:  dec.func = FnSll;
          FtSrlv:  dec.func = FnSrl;
          FtSrav:  dec.func = FnSra;
          default: legal = 1'b0;
        endcase
      end
      OpAddi:  begin dec.b = imm_sext; dec.is_signed = 1'b1; end
      OpAddiu: dec.b = imm_sext;
      OpSlti:  begin dec.b = imm_sext; dec.func = FnLt; dec.is_signed = 1'b1; end
      OpSltiu: begin dec.b = imm_sext; dec.func = FnLt; end
      OpAndi:  begin dec.b = imm_zext; dec.func = FnAnd; end
      OpOri:   begin dec.b = imm_zext; dec.func = FnOr; end
      OpXori:  begin dec.b = imm_zext; dec.func = FnXor; end
      OpLui:   begin dec.b = imm_zext; dec.func = FnSll; dec.a = 32'd16; end
      OpLw:    dec.b = imm_sext;
      OpSw:    begin dec.b = imm_sext; dec.wen = 1'b0; end
      OpBeq, OpBne, OpBlez, OpBgtz: begin
        dec.is_signed = 1'b1;
        dec.dst       = 5'd0;
        dec.wen       = 1'b0;
        dec.b         = (opcode == OpBeq || opcode == OpBne) ? rt_val : 32'd0;
        case (opcode)
          OpBeq:   dec.func = FnEq;
          OpBne:   dec.func = FnNeq;
          OpBlez:  dec.func = FnLez;
          default: dec.func = FnGtz;
        endcase
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      dec         = '0;
      dec.func    = FnAdd;
      dec.illegal = 1'b1;
    end
    if (dec.dst == 5'd0) dec.wen = 1'b0;
  end

  assign op = dec;

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decode plus a 2-entry skid buffer so in_ready can be a flop
// while still sustaining one instruction per cycle.
import alu_pkg::*;

module alu_issue #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_rs_val,
  input  logic [DATA_W-1:0] in_rt_val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic              out_signed,
  output logic [5:0]        out_func,
  output logic [4:0]        out_dst,
  output logic              out_wen,
  output logic              out_illegal
);

  alu_op_t in_op;
  alu_op_t main_q, main_d;
  alu_op_t skid_q, skid_d;
  logic    main_valid_q, main_valid_d;
  logic    skid_valid_q, skid_valid_d;
  logic    accept;
  logic    main_load;

  alu_decode u_decode (
    .instr  (in_instr),
    .rs_val (in_rs_val),
    .rt_val (in_rt_val),
    .op     (in_op)
  );

  assign in_ready  = ~skid_valid_q;
  assign accept    = in_valid & in_ready;
  assign main_load = ~main_valid_q | out_ready;

  // accept implies skid empty, so skid refill and skid->main never coincide.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_load) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = in_op;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = in_op;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid   = main_valid_q;
  assign out_a       = main_q.a;
  assign out_b       = main_q.b;
  assign out_signed  = main_q.is_signed;
  assign out_func    = main_q.func;
  assign out_dst     = main_q.dst;
  assign out_wen     = main_q.wen;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Directed self-checking bench for alu_issue: decode vectors, back-pressure,
// flush and asynchronous reset.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs_val;
  logic [31:0] in_rt_val;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic        out_signed;
  logic [5:0]  out_func;
  logic [4:0]  out_dst;
  logic        out_wen;
  logic        out_illegal;

  int checks   = 0;
  int failures = 0;

  logic [31:0] got_q[$];
  bit          mon_en = 1'b0;

  alu_issue #(.DATA_W(32)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_rs_val   (in_rs_val),
    .in_rt_val   (in_rt_val),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_signed  (out_signed),
    .out_func    (out_func),
    .out_dst     (out_dst),
    .out_wen     (out_wen),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  // Inputs only move at posedge+1, so a negedge sample predicts the next edge.
  always @(negedge clk) begin
    if (mon_en && reset_n && out_valid && out_ready && !flush) got_q.push_back(out_a);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic expect_op(input string tag, input logic [5:0] fn, input logic [31:0] a,
                           input logic [31:0] b, input logic s, input logic [4:0] dst,
                           input logic wen, input logic ill);
    check_eq({tag, ".valid"},   32'(out_valid),   32'd1);
    check_eq({tag, ".func"},    32'(out_func),    32'(fn));
    check_eq({tag, ".a"},       out_a,            a);
    check_eq({tag, ".b"},       out_b,            b);
    check_eq({tag, ".signed"},  32'(out_signed),  32'(s));
    check_eq({tag, ".dst"},     32'(out_dst),     32'(dst));
    check_eq({tag, ".wen"},     32'(out_wen),     32'(wen));
    check_eq({tag, ".illegal"}, 32'(out_illegal), 32'(ill));
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt);
    in_valid  = 1'b1;
    in_instr  = instr;
    in_rs_val = rs;
    in_rt_val = rt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_one(input logic [31:0] instr, input logic [31:0] rs,
                           input logic [31:0] rt);
    drive(instr, rs, rt);
    step();
    in_valid = 1'b0;
  endtask

  task automatic push(input string tag, input logic [31:0] instr, input logic [31:0] rs,
                      input logic [31:0] rt);
    bit ok;
    bit done = 1'b0;
    drive(instr, rs, rt);
    for (int i = 0; i < 20 && !done; i++) begin
      ok = in_ready;
      step();
      if (ok) done = 1'b1;
    end
    in_valid = 1'b0;
    if (!done) check_eq({tag, ".accept_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_rs_val = '0;
    in_rt_val = '0;
    out_ready = 1'b1;
    repeat (2) step();
    check_eq("rst.out_valid", 32'(out_valid), 32'd0);
    check_eq("rst.in_ready",  32'(in_ready),  32'd1);
    check_eq("rst.out_a",     out_a,          32'd0);
    check_eq("rst.out_func",  32'(out_func),  32'd0);
    reset_n = 1'b1;
    step();

    // Decode vectors, out_ready held high.
    issue_one(enc_i(6'h08, 5'd3, 5'd5, 16'hFFFF), 32'd7, 32'd0);
    expect_op("addi", 6'b000000, 32'd7, 32'hFFFF_FFFF, 1'b1, 5'd5, 1'b1, 1'b0);
    issue_one(enc_r(5'd0, 5'd4, 5'd2, 5'd3, 6'h03), 32'h55, 32'h8000_0000);
    expect_op("sra", 6'b100011, 32'd3, 32'h8000_0000, 1'b0, 5'd2, 1'b1, 1'b0);
    issue_one(enc_i(6'h0f, 5'd0, 5'd1, 16'h1234), 32'hDEAD_BEEF, 32'd0);
    expect_op("lui", 6'b100000, 32'd16, 32'h0000_1234, 1'b0, 5'd1, 1'b1, 1'b0);
    issue_one(enc_i(6'h06, 5'd3, 5'd0, 16'h0010), 32'hFFFF_FFFF, 32'h77);
    expect_op("blez", 6'b111101, 32'hFFFF_FFFF, 32'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    issue_one(enc_i(6'h3f, 5'd1, 5'd2, 16'h1234), 32'd5, 32'd6);
    expect_op("illegal", 6'b000000, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    issue_one(enc_i(6'h2b, 5'd2, 5'd7, 16'hFFF8), 32'h100, 32'h99);
    expect_op("sw", 6'b000000, 32'h100, 32'hFFFF_FFF8, 1'b0, 5'd7, 1'b0, 1'b0);
    issue_one(enc_r(5'd1, 5'd2, 5'd0, 5'd0, 6'h21), 32'h10, 32'h20);
    expect_op("addu_r0", 6'b000000, 32'h10, 32'h20, 1'b0, 5'd0, 1'b0, 1'b0);
    issue_one(enc_r(5'd1, 5'd2, 5'd9, 5'd0, 6'h2b), 32'h3, 32'h4);
    expect_op("sltu", 6'b110101, 32'h3, 32'h4, 1'b0, 5'd9, 1'b1, 1'b0);
    issue_one(enc_i(6'h05, 5'd1, 5'd2, 16'h0004), 32'hA, 32'hB);
    expect_op("bne", 6'b110001, 32'hA, 32'hB, 1'b1, 5'd0, 1'b0, 1'b0);
    issue_one(enc_i(6'h0c, 5'd1, 5'd8, 16'h8001), 32'hFFFF_0F0F, 32'd0);
    expect_op("andi", 6'b011000, 32'hFFFF_0F0F, 32'h0000_8001, 1'b0, 5'd8, 1'b1, 1'b0);
    step();
    check_eq("drain.out_valid", 32'(out_valid), 32'd0);

    // Back-pressure: 3 cycles of out_ready=0, then ops 1..6 must arrive in order.
    got_q.delete();
    mon_en    = 1'b1;
    out_ready = 1'b0;
    drive(enc_i(6'h09, 5'd1, 5'd1, 16'h0000), 32'd1, 32'd0);
    step();
    check_eq("bp1.out_a",    out_a,          32'd1);
    check_eq("bp1.in_ready", 32'(in_ready),  32'd1);
    drive(enc_i(6'h09, 5'd1, 5'd2, 16'h0000), 32'd2, 32'd0);
    step();
    check_eq("bp2.in_ready", 32'(in_ready),  32'd0);
    check_eq("bp2.out_a",    out_a,          32'd1);
    drive(enc_i(6'h09, 5'd1, 5'd3, 16'h0000), 32'd3, 32'd0);
    step();
    check_eq("bp3.in_ready",  32'(in_ready),  32'd0);
    check_eq("bp3.out_valid", 32'(out_valid), 32'd1);
    check_eq("bp3.out_a",     out_a,          32'd1);
    check_eq("bp3.out_dst",   32'(out_dst),   32'd1);
    out_ready = 1'b1;
    for (int i = 3; i <= 6; i++) begin
      push("bp_push", enc_i(6'h09, 5'd1, 5'(i), 16'h0000), 32'(i), 32'd0);
    end
    repeat (6) step();
    check_eq("bp.count", 32'(got_q.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < got_q.size()) check_eq("bp.order", got_q[i], 32'(i + 1));
    end
    check_eq("bp.idle", 32'(out_valid), 32'd0);

    // Flush with the buffer full, then again while ready: offered inputs are dropped.
    got_q.delete();
    out_ready = 1'b0;
    drive(enc_i(6'h09, 5'd1, 5'd1, 16'h0000), 32'h11, 32'd0);
    step();
    drive(enc_i(6'h09, 5'd1, 5'd1, 16'h0000), 32'h22, 32'd0);
    step();
    check_eq("fl.full", 32'(in_ready), 32'd0);
    drive(enc_i(6'h09, 5'd1, 5'd1, 16'h0000), 32'h33, 32'd0);
    flush = 1'b1;
    step();
    check_eq("fl.out_valid", 32'(out_valid), 32'd0);
    check_eq("fl.in_ready",  32'(in_ready),  32'd1);
    drive(enc_i(6'h09, 5'd1, 5'd1, 16'h0000), 32'h55, 32'd0);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_eq("fl2.out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    repeat (3) step();
    check_eq("fl.none", 32'(got_q.size()), 32'd0);
    issue_one(enc_i(6'h09, 5'd1, 5'd1, 16'h0000), 32'h44, 32'd0);
    check_eq("fl.next_a", out_a, 32'h44);
    repeat (2) step();
    check_eq("fl.one", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check_eq("fl.val", got_q[0], 32'h44);

    // Asynchronous reset between edges with the buffer full.
    out_ready = 1'b0;
    drive(enc_i(6'h09, 5'd1, 5'd1, 16'h0000), 32'h66, 32'd0);
    step();
    drive(enc_i(6'h09, 5'd1, 5'd1, 16'h0000), 32'h77, 32'd0);
    step();
    in_valid = 1'b0;
    check_eq("ar.full", 32'(in_ready), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("ar.out_valid", 32'(out_valid), 32'd0);
    check_eq("ar.in_ready",  32'(in_ready),  32'd1);
    check_eq("ar.out_a",     out_a,          32'd0);
    #2;
    reset_n = 1'b1;
    step();
    check_eq("ar.after", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Issue stage that drives the ALU's operand/function interface. Accepts a fetched MIPS instruction with its register-file read values, decodes it into the 6-bit ALU function code, the Signed flag and the A/B operands, and presents the result to the execute stage through a registered valid/ready handshake. It has a 2-entry skid buffer, so `in_ready` is a flop and the stage sustains one instruction per cycle under back-pressure.

## Interface
- `DATA_W`, 32, operand width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous squash of all held and incoming instructions.
- `in_valid`  in  1  instruction offered.
- `in_ready`  out  1  stage can accept; registered.
- `in_instr`  in  32  instruction word.
- `in_rs_val`, `in_rt_val`  in  32 each  register-file values of rs and rt.
- `out_valid`  out  1  decoded op offered to execute.
- `out_ready`  in  1  execute accepts.
- `out_a`, `out_b`  out  32 each  ALU operand A and B. For shifts, `out_a[4:0]` is the shift amount.
- `out_signed`  out  1  ALU Signed input.
- `out_func`  out  6  ALU function code.
- `out_dst`  out  5  destination register.
- `out_wen`  out  1  register write enable.
- `out_illegal`  out  1  instruction not decodable.

## Operation
- **Function codes**
  - ADD 000000, SUB 000001.
  - AND 011000, OR 011110, XOR 010110, NOR 010001, PASS-A 011010.
  - SLL 100000, SRL 100001, SRA 100011.
  - EQ 110011, NEQ 110001, LT 110101, LEZ 111101, GEZ 111001, GTZ 111111.
- **R-type** (opcode 0), selected by funct; A=rs, B=rt, dst=rd unless noted.
  - add 0x20 ADD s=1; addu 0x21 ADD s=0; sub 0x22 SUB s=1; subu 0x23 SUB s=0.
  - and 0x24, or 0x25, xor 0x26, nor 0x27 map to the matching logic op, s=0.
  - slt 0x2a LT s=1; sltu 0x2b LT s=0.
  - sll 0x00, srl 0x02, sra 0x03: A = zero-extended shamt, B=rt.
  - sllv 0x04, srlv 0x06, srav 0x07: A=rs, B=rt.
- **I-type**: A=rs, dst=rt.
  - addi 0x08 ADD s=1; addiu 0x09 ADD s=0; slti 0x0a LT s=1; sltiu 0x0b LT s=0. B = sign-extended imm.
  - andi 0x0c, ori 0x0d, xori 0x0e: B = zero-extended imm, s=0.
  - lui 0x0f: SLL with A=16, B=zero-extended imm.
  - lw 0x23: ADD s=0, B = sign-extended imm, wen=1.
  - sw 0x2b: ADD s=0, B = sign-extended imm, wen=0.
- **Branches**: s=1, wen=0, dst=0.
  - beq 0x04 EQ, bne 0x05 NEQ: A=rs, B=rt.
  - blez 0x06 LEZ, bgtz 0x07 GTZ: A=rs, B=0.
- **Write enable**: `out_wen` is forced to 0 whenever dst=0.
- **Illegal instructions**: any other opcode/funct gives func=ADD, A=B=0, s=0, dst=0, wen=0, illegal=1, and is still issued.

## Timing
- **Reset values**: `out_valid`=0, `in_ready`=1, all other outputs 0, both buffer entries empty.
- **Latency**: a transfer (`in_valid`&`in_ready`) at edge N is presented on `out_*` after edge N, i.e. 1 cycle.
- **Output stability**: while `out_valid`=1 and `out_ready`=0, every `out_*` holds constant.
- **Skid buffer**
  - The main register feeds the outputs.
  - A transfer that arrives while main is full and not draining goes to the skid entry.
  - `in_ready` = skid empty, registered.
  - When main drains, skid moves to main on the same edge.
- **Order**: strict FIFO; no reordering and no duplication.
- **Flush**: with `flush`=1 at edge N, both entries are empty after N and `out_valid`=0. Any input offered in that cycle is dropped even if `in_ready`=1. `in_ready`=1 after N.
- **Simultaneous events**
  - flush has priority over accept and drain.
  - Accept and drain in the same cycle keep occupancy unchanged.
- **Asynchronous reset**: any mid-operation assertion empties the buffer immediately.

## Structure
- **Package `alu_pkg`** holds:
  - the 16 function-code constants;
  - the opcode and funct constants;
  - a packed struct `alu_op_t` with fields a, b, signed, func, dst, wen, illegal.
- **Sub-module `alu_decode`**: purely combinational, (instr, rs_val, rt_val) → `alu_op_t`.
- **Top level**: the 2-entry skid buffer of `alu_op_t` plus handshake control.

## Test plan
- addi r5,r3,-1 with rs=7, out_ready=1 → one cycle later: func=000000, A=7, B=0xFFFFFFFF, s=1, dst=5, wen=1.
- sra r2,r4,3 with rt=0x80000000 → func=100011, A=3, B=0x80000000, s=0. Then lui r1,0x1234 → func=100000, A=16, B=0x00001234.
- Back-to-back ops 1..6 with out_ready held 0 for 3 cycles → in_ready drops after 2 accepts; outputs hold; all 6 arrive in order with no loss once out_ready=1.
- blez rs=0xFFFFFFFF → func=111101, B=0, wen=0. Opcode 0x3f → illegal=1, wen=0.
- Buffer full, then flush with in_valid=1 → out_valid=0 next cycle, flushed input never appears, in_ready=1.
- Assert reset_n low mid-stream between edges → out_valid=0 immediately, in_ready=1.
